priority_arbiter_fsm: RTL and testbench



---
 rtl/priority_arbiter_fsm.sv | 70 +++++++
 tb/tb_priority_arbiter_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_fsm.sv
// priority_arbiter_fsm: 8-requester fixed/round-robin arbiter with release handshake and hold-time limit
module priority_arbiter_fsm #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout_pulse
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state;
  logic [2:0]      owner, last, win, idx;
  logic [CW-1:0]   hold_cnt;
  logic            done;
  // later loop iterations override earlier ones, so the last visited index has top priority
  always_comb begin
    win = '0;
    idx = '0;
    if (mode) begin
      for (int k = 8; k >= 1; k--) begin
        idx = last - 3'(k);
        if (req[idx]) win = idx;
      end
    end else begin
      for (int i = 0; i < 8; i++)
        if (req[i]) win = 3'(i);
    end
  end
  assign done = rel || !req[owner] || hold_cnt == CW'(HOLD_MAX);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      gnt_id        <= '0;
      gnt_valid     <= 1'b0;
      timeout_pulse <= 1'b0;
      owner         <= '0;
      last          <= '0;
      hold_cnt      <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state     <= GRANT;
          owner     <= win;
          last      <= win;
          gnt       <= 8'(1) << win;
          gnt_id    <= win;
          gnt_valid <= 1'b1;
          hold_cnt  <= CW'(1);
        end
      end else if (done) begin
        state         <= IDLE;
        gnt           <= '0;
        gnt_id        <= '0;
        gnt_valid     <= 1'b0;
        hold_cnt      <= '0;
        timeout_pulse <= !rel && req[owner];
      end else begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_priority_arbiter_fsm.sv
// tb_priority_arbiter_fsm: directed self-checking bench for priority_arbiter_fsm with HOLD_MAX=4
module tb_priority_arbiter_fsm;
  logic       clk = 0, rst = 1, mode = 0, rel = 0;
  logic [7:0] req = 8'hFF;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid, timeout_pulse;
  int         total = 0, passed = 0;

  priority_arbiter_fsm #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req), .rel(rel),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_out;
    req = 8'h00;
    rel = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst = 1; req = 8'hFF; mode = 0; rel = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if (gnt !== 8'h00) $display("FAIL reset_gnt c%0d: got %h want 00", c, gnt); else passed++;
      total++; if (gnt_id !== 3'd0) $display("FAIL reset_id c%0d: got %0d want 0", c, gnt_id); else passed++;
      total++; if (gnt_valid !== 1'b0) $display("FAIL reset_valid c%0d: got %b want 0", c, gnt_valid); else passed++;
      total++; if (timeout_pulse !== 1'b0) $display("FAIL reset_tp c%0d: got %b want 0", c, timeout_pulse); else passed++;
    end
    rst = 0;
    tick;
    total++; if (gnt_id !== 3'd7) $display("FAIL reset_first_id: got %0d want 7", gnt_id); else passed++;
    total++; if (gnt !== 8'h80) $display("FAIL reset_first_gnt: got %h want 80", gnt); else passed++;
    idle_out;
  endtask

  task automatic test_fixed;
    mode = 0; req = 8'b0011_0100;
    tick;
    total++; if (gnt !== 8'h20) $display("FAIL fixed_gnt: got %h want 20", gnt); else passed++;
    total++; if (gnt_id !== 3'd5) $display("FAIL fixed_id: got %0d want 5", gnt_id); else passed++;
    total++; if (gnt_valid !== 1'b1) $display("FAIL fixed_valid: got %b want 1", gnt_valid); else passed++;
    rel = 1; req = 8'b0001_0100;
    tick;
    total++; if (gnt !== 8'h00) $display("FAIL fixed_gap: got %h want 00", gnt); else passed++;
    rel = 0;
    tick;
    total++; if (gnt !== 8'h10) $display("FAIL fixed_gnt2: got %h want 10", gnt); else passed++;
    total++; if (gnt_id !== 3'd4) $display("FAIL fixed_id2: got %0d want 4", gnt_id); else passed++;
    idle_out;
  endtask

  task automatic test_round_robin;
    int exp_ids[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rst = 1;
    tick;
    rst = 0; mode = 1; req = 8'hFF; rel = 0;
    foreach (exp_ids[n]) begin
      tick;
      total++; if (gnt_id !== 3'(exp_ids[n])) $display("FAIL rr_id %0d: got %0d want %0d", n, gnt_id, exp_ids[n]); else passed++;
      total++; if (gnt !== (8'd1 << exp_ids[n])) $display("FAIL rr_gnt %0d: got %h want %h", n, gnt, 8'd1 << exp_ids[n]); else passed++;
      rel = 1;
      tick;
      total++; if (gnt !== 8'h00) $display("FAIL rr_gap %0d: got %h want 00", n, gnt); else passed++;
      rel = 0;
    end
    idle_out;
  endtask

  task automatic test_timeout;
    mode = 1; req = 8'h08; rel = 0;
    for (int c = 1; c <= 4; c++) begin
      tick;
      total++; if (gnt !== 8'h08) $display("FAIL to_hold c%0d: got %h want 08", c, gnt); else passed++;
      total++; if (timeout_pulse !== 1'b0) $display("FAIL to_early c%0d: got %b want 0", c, timeout_pulse); else passed++;
    end
    tick;
    total++; if (gnt !== 8'h00) $display("FAIL to_drop: got %h want 00", gnt); else passed++;
    total++; if (timeout_pulse !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout_pulse); else passed++;
    tick;
    total++; if (gnt !== 8'h08) $display("FAIL to_regrant: got %h want 08", gnt); else passed++;
    total++; if (timeout_pulse !== 1'b0) $display("FAIL to_pulse_len: got %b want 0", timeout_pulse); else passed++;
    tick;
    tick;
    tick;
    total++; if (gnt !== 8'h08) $display("FAIL to_cycle4: got %h want 08", gnt); else passed++;
    rel = 1;
    tick;
    total++; if (gnt !== 8'h00) $display("FAIL to_rel_drop: got %h want 00", gnt); else passed++;
    total++; if (timeout_pulse !== 1'b0) $display("FAIL to_rel_suppress: got %b want 0", timeout_pulse); else passed++;
    rel = 0;
    idle_out;
  endtask

  task automatic test_withdraw;
    mode = 0; req = 8'h81; rel = 0;
    tick;
    total++; if (gnt_id !== 3'd7) $display("FAIL wd_id: got %0d want 7", gnt_id); else passed++;
    tick;
    total++; if (gnt !== 8'h80) $display("FAIL wd_cycle2: got %h want 80", gnt); else passed++;
    req = 8'h01;
    tick;
    total++; if (gnt !== 8'h00) $display("FAIL wd_drop: got %h want 00", gnt); else passed++;
    total++; if (timeout_pulse !== 1'b0) $display("FAIL wd_tp: got %b want 0", timeout_pulse); else passed++;
    tick;
    total++; if (gnt_id !== 3'd0) $display("FAIL wd_next_id: got %0d want 0", gnt_id); else passed++;
    total++; if (gnt !== 8'h01) $display("FAIL wd_next_gnt: got %h want 01", gnt); else passed++;
    idle_out;
  endtask

  task automatic test_reset_mid_grant;
    mode = 1; req = 8'hFF; rel = 0;
    tick;
    total++; if (gnt_id !== 3'd7) $display("FAIL rm_first: got %0d want 7", gnt_id); else passed++;
    rel = 1;
    tick;
    rel = 0;
    tick;
    tick;
    tick;
    total++; if (gnt_id !== 3'd6) $display("FAIL rm_id6: got %0d want 6", gnt_id); else passed++;
    rst = 1;
    tick;
    total++; if (gnt !== 8'h00) $display("FAIL rm_gnt: got %h want 00", gnt); else passed++;
    total++; if (gnt_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", gnt_valid); else passed++;
    total++; if (timeout_pulse !== 1'b0) $display("FAIL rm_tp: got %b want 0", timeout_pulse); else passed++;
    rst = 0;
    tick;
    total++; if (gnt_id !== 3'd7) $display("FAIL rm_ptr: got %0d want 7", gnt_id); else passed++;
    idle_out;
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_round_robin;
    test_timeout;
    test_withdraw;
    test_reset_mid_grant;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
